// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, memory write
// size codes, FSM state type and access-size helpers.
package lsu_pkg;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size-coded write strobe understood by the data memory
  localparam logic [1:0] MEM_WR_NONE = 2'd0;
  localparam logic [1:0] MEM_WR_BYTE = 2'd1;
  localparam logic [1:0] MEM_WR_HALF = 2'd2;
  localparam logic [1:0] MEM_WR_WORD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_CAP,
    ST_WRITE,
    RESP
  } state_t;

  // Number of bytes touched by a (legal) funct3; the sign bit is ignored.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  // Write strobe code for a legal store funct3.
  function automatic logic [1:0] store_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   store_size = MEM_WR_BYTE;
      2'b01:   store_size = MEM_WR_HALF;
      default: store_size = MEM_WR_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channels between the execute stage (master) and the
// load/store unit (slave).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Byte/half selection and sign/zero extension of a raw memory word whose
// byte 0 is the addressed byte.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // Pick the low byte/half and extend according to funct3
  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'd0, raw[7:0]};
      F3_HU:   data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, registered memory controls,
// one-cycle memory read latency, extended load results on a valid/ready
// response channel. Illegal funct3 and out-of-bounds accesses are answered
// immediately with an error and never reach the memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE     = 1024,
  parameter bit          CHECK_BOUNDS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    lsu,
  output logic [31:0]         mem_rd_addr,
  input  logic [31:0]         mem_rd_data,
  output logic [1:0]          mem_wr,
  output logic [31:0]         mem_wr_addr,
  output logic [31:0]         mem_wr_data
);

  state_t      state_reg;
  logic [2:0]  funct3_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_data_reg;
  logic [4:0]  resp_rd_reg;
  logic        resp_err_reg;
  logic [31:0] mem_rd_addr_reg;
  logic [1:0]  mem_wr_reg;
  logic [31:0] mem_wr_addr_reg;
  logic [31:0] mem_wr_data_reg;

  logic        funct3_ok;
  logic [32:0] last_byte;
  logic        out_of_bounds;
  logic        req_err;
  logic [31:0] ext_data;

  // Legality of the incoming request: funct3 decode plus 33-bit bounds check
  always_comb begin
    funct3_ok = 1'b0;
    case (lsu.req_funct3)
      F3_B, F3_H, F3_W: funct3_ok = 1'b1;
      F3_BU, F3_HU:     funct3_ok = !lsu.req_store;
      default:          funct3_ok = 1'b0;
    endcase
    last_byte     = {1'b0, lsu.req_addr} + 33'(access_bytes(lsu.req_funct3)) - 33'd1;
    out_of_bounds = CHECK_BOUNDS && (last_byte >= 33'(MEM_SIZE));
    req_err       = !funct3_ok || out_of_bounds;
  end

  load_extend u_load_extend (
    .funct3 (funct3_reg),
    .raw    (mem_rd_data),
    .data   (ext_data)
  );

  // Main FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      funct3_reg      <= F3_B;
      resp_valid_reg  <= 1'b0;
      resp_data_reg   <= 32'd0;
      resp_rd_reg     <= 5'd0;
      resp_err_reg    <= 1'b0;
      mem_rd_addr_reg <= 32'd0;
      mem_wr_reg      <= MEM_WR_NONE;
      mem_wr_addr_reg <= 32'd0;
      mem_wr_data_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lsu.req_valid) begin
            resp_rd_reg <= lsu.req_rd;
            funct3_reg  <= lsu.req_funct3;
            if (req_err) begin
              // No memory access; answer straight away
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_data_reg  <= 32'd0;
              state_reg      <= RESP;
            end else if (lsu.req_store) begin
              mem_wr_reg      <= store_size(lsu.req_funct3);
              mem_wr_addr_reg <= lsu.req_addr;
              mem_wr_data_reg <= lsu.req_wdata;
              state_reg       <= ST_WRITE;
            end else begin
              mem_rd_addr_reg <= lsu.req_addr;
              state_reg       <= LD_WAIT;
            end
          end
        end
        LD_WAIT: state_reg <= LD_CAP;
        LD_CAP: begin
          resp_data_reg  <= ext_data;
          resp_err_reg   <= 1'b0;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        ST_WRITE: begin
          // Strobe lasts exactly one cycle; address/data keep their values
          mem_wr_reg     <= MEM_WR_NONE;
          resp_data_reg  <= 32'd0;
          resp_err_reg   <= 1'b0;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (lsu.resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign lsu.req_ready  = (state_reg == IDLE);
  assign lsu.resp_valid = resp_valid_reg;
  assign lsu.resp_data  = resp_data_reg;
  assign lsu.resp_rd    = resp_rd_reg;
  assign lsu.resp_err   = resp_err_reg;
  assign mem_rd_addr    = mem_rd_addr_reg;
  assign mem_wr         = mem_wr_reg;
  assign mem_wr_addr    = mem_wr_addr_reg;
  assign mem_wr_data    = mem_wr_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table plus hand-written
// backpressure and reset-during-store sequences, with a byte memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [1:0]  mem_wr;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  int checks = 0;
  int errors = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_SIZE(1024), .CHECK_BOUNDS(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu         (bus),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr      (mem_wr),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory with one-cycle registered read
  logic [7:0] mem [0:1023];
  logic [9:0] wa0, wa1, wa2, wa3, ra0, ra1, ra2, ra3;
  assign wa0 = mem_wr_addr[9:0];
  assign wa1 = wa0 + 10'd1;
  assign wa2 = wa0 + 10'd2;
  assign wa3 = wa0 + 10'd3;
  assign ra0 = mem_rd_addr[9:0];
  assign ra1 = ra0 + 10'd1;
  assign ra2 = ra0 + 10'd2;
  assign ra3 = ra0 + 10'd3;

  always @(posedge clk) begin
    if (mem_wr != 2'd0) mem[wa0] <= mem_wr_data[7:0];
    if (mem_wr >= 2'd2) mem[wa1] <= mem_wr_data[15:8];
    if (mem_wr == 2'd3) begin
      mem[wa2] <= mem_wr_data[23:16];
      mem[wa3] <= mem_wr_data[31:24];
    end
    mem_rd_data <= {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
  end

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [1:0]  exp_wr;
  } vec_t;

  vec_t vecs [0:21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_store  = v.store;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_rd     = v.rd;
  endtask

  // Wait (bounded) until the unit is ready; returns 0 on timeout
  task automatic wait_ready(output bit ok);
    int w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    ok = bus.req_ready;
    if (!ok) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    bit ok;
    int lat;
    int exp_lat;
    exp_lat = v.exp_err ? 0 : (v.store ? 1 : 2);
    bus.resp_ready = 1'b1;
    wait_ready(ok);
    if (!ok) return;
    drive_req(v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk($sformatf("v%0d mem_wr_at_accept", idx), 32'(mem_wr), 32'(v.exp_wr));
    if (v.exp_wr != 2'd0)
      chk($sformatf("v%0d mem_wr_addr", idx), mem_wr_addr, v.addr);
    lat = 0;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat));
    chk($sformatf("v%0d resp_data", idx), bus.resp_data, v.exp_data);
    chk($sformatf("v%0d resp_err", idx), 32'(bus.resp_err), 32'(v.exp_err));
    chk($sformatf("v%0d resp_rd", idx), 32'(bus.resp_rd), 32'(v.rd));
    chk($sformatf("v%0d mem_wr_at_resp", idx), 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d resp_valid_after_hs", idx), 32'(bus.resp_valid), 32'd0);
    chk($sformatf("v%0d req_ready_after_hs", idx), 32'(bus.req_ready), 32'd1);
    $display("TXN %0d store=%0b f3=%0d addr=0x%08h data=0x%08h err=%0b lat=%0d",
             idx, v.store, v.f3, v.addr, bus.resp_data, bus.resp_err, lat);
  endtask

  initial begin
    bit ok;
    int lat;
    vec_t v;

    //            store f3      addr          wdata         rd    exp_data      err   wr
    vecs[0]  = '{1'b1, F3_W,  32'h10,       32'hDEADBEEF, 5'd1, 32'h0,        1'b0, 2'd3};
    vecs[1]  = '{1'b0, F3_W,  32'h10,       32'h0,        5'd2, 32'hDEADBEEF, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, F3_B,  32'h20,       32'h00000080, 5'd3, 32'h0,        1'b0, 2'd1};
    vecs[3]  = '{1'b1, F3_H,  32'h22,       32'h00008001, 5'd4, 32'h0,        1'b0, 2'd2};
    vecs[4]  = '{1'b0, F3_B,  32'h20,       32'h0,        5'd5, 32'hFFFFFF80, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, F3_BU, 32'h20,       32'h0,        5'd6, 32'h00000080, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, F3_H,  32'h22,       32'h0,        5'd8, 32'hFFFF8001, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, F3_HU, 32'h22,       32'h0,        5'd9, 32'h00008001, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, F3_W,  32'h30,       32'hAABBCCDD, 5'd10, 32'h0,       1'b0, 2'd3};
    vecs[9]  = '{1'b1, F3_B,  32'h31,       32'h12345678, 5'd11, 32'h0,       1'b0, 2'd1};
    vecs[10] = '{1'b0, F3_W,  32'h30,       32'h0,        5'd12, 32'hAABB78DD, 1'b0, 2'd0};
    vecs[11] = '{1'b0, F3_H,  32'h11,       32'h0,        5'd13, 32'hFFFFADBE, 1'b0, 2'd0};
    vecs[12] = '{1'b1, F3_W,  32'h3FC,      32'h11223344, 5'd14, 32'h0,       1'b0, 2'd3};
    vecs[13] = '{1'b0, F3_W,  32'h3FC,      32'h0,        5'd15, 32'h11223344, 1'b0, 2'd0};
    vecs[14] = '{1'b0, F3_B,  32'h3FF,      32'h0,        5'd16, 32'h00000011, 1'b0, 2'd0};
    vecs[15] = '{1'b0, F3_W,  32'h3FE,      32'h0,        5'd17, 32'h0,       1'b1, 2'd0};
    vecs[16] = '{1'b0, F3_H,  32'h3FF,      32'h0,        5'd18, 32'h0,       1'b1, 2'd0};
    vecs[17] = '{1'b1, 3'b011, 32'h40,      32'hFFFFFFFF, 5'd19, 32'h0,       1'b1, 2'd0};
    vecs[18] = '{1'b0, 3'b110, 32'h10,      32'h0,        5'd20, 32'h0,       1'b1, 2'd0};
    vecs[19] = '{1'b1, F3_B,  32'hFFFFFFFF, 32'h000000AA, 5'd21, 32'h0,       1'b1, 2'd0};
    vecs[20] = '{1'b1, F3_BU, 32'h20,       32'h000000FF, 5'd22, 32'h0,       1'b1, 2'd0};
    vecs[21] = '{1'b0, F3_BU, 32'h3FF,      32'h0,        5'd23, 32'h00000011, 1'b0, 2'd0};

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_rd     = 5'd0;
    bus.resp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset resp_data", bus.resp_data, 32'd0);
    chk("reset resp_rd", 32'(bus.resp_rd), 32'd0);
    chk("reset resp_err", 32'(bus.resp_err), 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset mem_rd_addr", mem_rd_addr, 32'd0);
    chk("reset mem_wr_addr", mem_wr_addr, 32'd0);
    chk("reset mem_wr_data", mem_wr_data, 32'd0);

    for (int i = 0; i < 22; i++) run_txn(i, vecs[i]);

    // Backpressure: load rd=7 held for 5 cycles with resp_ready low
    bus.resp_ready = 1'b0;
    v = '{1'b0, F3_W, 32'h30, 32'h0, 5'd7, 32'hAABB78DD, 1'b0, 2'd0};
    wait_ready(ok);
    if (ok) begin
      drive_req(v);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 0;
      while (!bus.resp_valid && lat < 10) begin
        @(posedge clk); #1; lat++;
      end
      chk("bp latency", 32'(lat), 32'd2);
      for (int c = 0; c < 5; c++) begin
        chk("bp resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("bp resp_data", bus.resp_data, 32'hAABB78DD);
        chk("bp resp_rd", 32'(bus.resp_rd), 32'd7);
        chk("bp resp_err", 32'(bus.resp_err), 32'd0);
        chk("bp req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp resp_valid_after_hs", 32'(bus.resp_valid), 32'd0);
      chk("bp req_ready_after_hs", 32'(bus.req_ready), 32'd1);
      $display("TXN bp load rd=7 data=0x%08h held 5 cycles", bus.resp_data);
    end

    // Reset one cycle after accepting SW @0x40: write lands, nothing reported
    v = '{1'b1, F3_W, 32'h40, 32'h55667788, 5'd9, 32'h0, 1'b0, 2'd3};
    wait_ready(ok);
    if (ok) begin
      drive_req(v);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("rst mem_wr_before", 32'(mem_wr), 32'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst resp_data", bus.resp_data, 32'd0);
      chk("rst resp_rd", 32'(bus.resp_rd), 32'd0);
      chk("rst resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst mem_wr", 32'(mem_wr), 32'd0);
      chk("rst mem_rd_addr", mem_rd_addr, 32'd0);
      chk("rst mem_wr_addr", mem_wr_addr, 32'd0);
      chk("rst mem_wr_data", mem_wr_data, 32'd0);
      $display("TXN reset during store @0x40");
      run_txn(100, '{1'b0, F3_W, 32'h40, 32'h0, 5'd24, 32'h55667788, 1'b0, 2'd0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
